// File: rtl/music_pkg.sv
// Shared types, note codes and divisor table for the music sequencer.
// Imported by the sequencer top and its note ROM.
package music_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_NOTE,
    S_GAP,
    S_DONE
  } state_t;

  localparam int WORD_W    = 9;
  localparam int CODE_HI   = 8;
  localparam int CODE_LO   = 3;
  localparam int DUR_HI    = 2;
  localparam int DUR_LO    = 0;
  localparam int NUM_NOTES = 37;
  localparam int CNT_W     = 27;
  localparam int DIV_W     = 20;

  localparam logic [5:0] C_REST = 6'd0;
  localparam logic [5:0] C_C3   = 6'd1;
  localparam logic [5:0] C_C4   = 6'd13;
  localparam logic [5:0] C_E4   = 6'd17;
  localparam logic [5:0] C_G4   = 6'd20;
  localparam logic [5:0] C_A4   = 6'd22;
  localparam logic [5:0] C_C5   = 6'd25;
  localparam logic [5:0] C_B5   = 6'd36;

  typedef logic [NUM_NOTES-1:0][DIV_W-1:0] div_tab_t;

  // Elaboration-time table; entry 0 is the rest slot.
  function automatic div_tab_t div_table(input int clk_hz);
    div_tab_t t;
    real      f;
    t = '0;
    for (int k = 1; k < NUM_NOTES; k++) begin
      f = 440.0 * (2.0 ** ((real'(k) - 22.0) / 12.0));
      t[k] = DIV_W'($rtoi(real'(clk_hz) / (2.0 * f) + 0.5) - 1);
    end
    return t;
  endfunction

endpackage

// File: rtl/note_rom.sv
// Song storage: synchronous 64x9 ROM, one-cycle read latency.
// Word layout is {code[5:0], dur[2:0]}.
module note_rom
  import music_pkg::*;
(
  input  logic              clk,
  input  logic [5:0]        addr,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] word_q;

  always_comb begin
    word_d = {C_REST, 3'd0};
    case (addr)
      6'd0:    word_d = {C_A4,   3'd0};
      6'd1:    word_d = {C_REST, 3'd1};
      6'd2:    word_d = {C_C4,   3'd0};
      6'd3:    word_d = {C_B5,   3'd2};
      6'd4:    word_d = {C_E4,   3'd1};
      6'd5:    word_d = {C_G4,   3'd1};
      6'd6:    word_d = {C_C5,   3'd3};
      6'd7:    word_d = {C_C3,   3'd0};
      default: word_d = {C_REST, 3'd0};
    endcase
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/music_sequencer.sv
// ROM-driven note sequencer: steps through the song, emitting divisor,
// mute and progress strobes with pause, stop and loop control.
module music_sequencer
  import music_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int BEAT_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int SONG_LEN    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
  output logic [DIV_W-1:0]  note_div,
  output logic              mute,
  output logic              playing,
  output logic [5:0]        song_idx,
  output logic              done_pulse
);

  localparam div_tab_t DIV_TAB = div_table(CLK_HZ);
  localparam logic [CNT_W-1:0] BEAT_C = CNT_W'(BEAT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LD =
    CNT_W'((GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0);
  localparam logic [5:0] LAST_IDX = 6'(SONG_LEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DIV_W-1:0]  note_div_q, note_div_d;
  logic              mute_q, mute_d;
  logic              tone_mute_q, tone_mute_d;
  logic              playing_q, playing_d;
  logic [5:0]        idx_q, idx_d;
  logic              done_q, done_d;

  logic [WORD_W-1:0] rom_w;
  logic [5:0]        code;
  logic [2:0]        dur;
  logic              is_rest;
  logic [DIV_W-1:0]  tab_div;
  logic [CNT_W-1:0]  note_len;
  logic              frz;
  logic              advance;

  note_rom u_rom (
    .clk  (clk),
    .addr (idx_d),
    .word (rom_w)
  );

  assign code    = rom_w[CODE_HI:CODE_LO];
  assign dur     = rom_w[DUR_HI:DUR_LO];
  assign is_rest = (code == C_REST) || (code >= 6'(NUM_NOTES));
  assign tab_div = is_rest ? '0 : DIV_TAB[code];
  // NOTE count loaded as (dur+1)*beat - gap - 1, counting down to 0.
  assign note_len =
    ({{(CNT_W-3){1'b0}}, dur} + ONE_C) * BEAT_C - GAP_C - ONE_C;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    note_div_d  = note_div_q;
    tone_mute_d = tone_mute_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    advance     = 1'b0;
    frz = pause && (state_q == S_NOTE || state_q == S_GAP);

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        state_d     = S_NOTE;
        note_div_d  = tab_div;
        tone_mute_d = is_rest;
        cnt_d       = note_len;
      end
      S_NOTE: begin
        if (!frz) begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE_C;
          end else if (GAP_CYCLES == 1) begin
            advance = 1'b1;
          end else begin
            state_d = S_GAP;
            cnt_d   = GAP_LD;
          end
        end
      end
      S_GAP: begin
        if (!frz) begin
          if (cnt_q != '0) cnt_d = cnt_q - ONE_C;
          else advance = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      cnt_d = '0;
      if (idx_q != LAST_IDX) begin
        idx_d   = idx_q + 6'd1;
        state_d = S_LOAD;
      end else begin
        done_d  = 1'b1;
        idx_d   = loop_en ? 6'd0 : idx_q;
        state_d = loop_en ? S_LOAD : S_DONE;
      end
    end

    if (stop) begin
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
    end

    playing_d = (state_d == S_LOAD) || (state_d == S_NOTE) ||
                (state_d == S_GAP);
    mute_d = !((state_d == S_NOTE) && !tone_mute_d && !frz);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      note_div_q  <= '0;
      mute_q      <= 1'b1;
      tone_mute_q <= 1'b1;
      playing_q   <= 1'b0;
      idx_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      note_div_q  <= note_div_d;
      mute_q      <= mute_d;
      tone_mute_q <= tone_mute_d;
      playing_q   <= playing_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
    end
  end

  assign note_div   = note_div_q;
  assign mute       = mute_q;
  assign playing    = playing_q;
  assign song_idx   = idx_q;
  assign done_pulse = done_q;

endmodule

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the crystal clock frequency used to build the divisor table.
REQ-002 SHALL have parameter BEAT_CYCLES, default 12_500_000, meaning clk cycles per beat (1/8 s).
REQ-003 SHALL have parameter GAP_CYCLES, default 500_000, meaning the silent articulation cycles at the end of each note; legal range 1..BEAT_CYCLES-1.
REQ-004 SHALL have parameter SONG_LEN, default 64, meaning the number of note-ROM entries; legal range 2..64.
REQ-005 SHALL have port clk, input, 1 bit: the system clock; one clock domain only.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: a play request, sampled every cycle.
REQ-008 SHALL have port stop, input, 1 bit: an abort request, sampled every cycle.
REQ-009 SHALL have port pause, input, 1 bit: a level input that freezes playback while high.
REQ-010 SHALL have port loop_en, input, 1 bit: when high, the song restarts at the end.
REQ-011 SHALL have port note_div, output, 20 bits: the divisor for the downstream note generator.
REQ-012 SHALL have port mute, output, 1 bit: when high, downstream audio is silenced and note_div is don't-care.
REQ-013 SHALL have port playing, output, 1 bit: high in states LOAD, NOTE and GAP.
REQ-014 SHALL have port song_idx, output, 6 bits: the index of the current ROM entry.
REQ-015 SHALL have port done_pulse, output, 1 bit: a one-cycle strobe at song end.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, NOTE, GAP and DONE, and all outputs SHALL be registered.
REQ-017 Each ROM word SHALL be 9 bits: code[8:3] and dur[2:0]; a note SHALL last dur+1 beats.
REQ-018 Code 0 SHALL be a rest, codes 1..36 SHALL be chromatic C3..B5, and codes 37..63 SHALL be treated as a rest.
REQ-019 The divisor for code k SHALL be CLK_HZ/(2*f_k) - 1, with f_k = 440*2^((k-22)/12) Hz, rounded to nearest; for example A4 (code 22) SHALL give 113635.
REQ-020 IDLE or DONE with start=1 SHALL go to LOAD with song_idx=0 in the next cycle; in LOAD, NOTE and GAP, start SHALL be ignored.
REQ-021 LOAD SHALL last exactly 1 cycle, the ROM read latency, with mute=1.
REQ-022 On the LOAD->NOTE transition, note_div SHALL be updated from the ROM word.
REQ-023 On the LOAD->NOTE transition, mute SHALL be set to 1 for a rest and to 0 otherwise.
REQ-024 NOTE SHALL last (dur+1)*BEAT_CYCLES - GAP_CYCLES cycles.
REQ-025 GAP SHALL last GAP_CYCLES-1 cycles with mute=1; when GAP_CYCLES=1, NOTE SHALL go directly to the next LOAD.
REQ-026 The total period per note, from LOAD through GAP, SHALL be exactly (dur+1)*BEAT_CYCLES cycles.
REQ-027 At the end of GAP, if song_idx < SONG_LEN-1, song_idx SHALL increment and the FSM SHALL go to LOAD.
REQ-028 At the end of GAP, if song_idx = SONG_LEN-1 and loop_en=1, song_idx SHALL wrap to 0, the FSM SHALL go to LOAD, and done_pulse SHALL be 1 for one cycle.
REQ-029 At the end of GAP, if song_idx = SONG_LEN-1 and loop_en=0, the FSM SHALL go to DONE with done_pulse=1 for one cycle and mute=1.
REQ-030 pause=1 in NOTE or GAP SHALL freeze the duration counter and the state, and SHALL force mute=1.
REQ-031 When pause is released, counting SHALL resume with no lost or added cycles, and mute SHALL return to its pre-pause value.
REQ-032 pause SHALL be ignored in IDLE, LOAD and DONE.
REQ-033 stop=1 in any state SHALL move the FSM to IDLE next cycle, with mute=1, playing=0 and song_idx=0.
REQ-034 When stop and start are asserted together, stop SHALL win.
REQ-035 The duration counter SHALL be 27 bits wide, sized for 8*BEAT_CYCLES, and SHALL never wrap in legal use.

Reset
REQ-036 When rst=1, the block SHALL enter IDLE on the next clk edge.
REQ-037 Reset values SHALL be: note_div=0, mute=1, playing=0, song_idx=0, done_pulse=0, duration counter=0.
REQ-038 Reset mid-song SHALL abort playback with no done_pulse.

Structure
REQ-039 The note-code constants, the 37-entry divisor table function, the state encodings and the ROM word field positions SHALL reside in the shared package music_pkg.
REQ-040 The song contents SHALL reside in the sub-module note_rom: a synchronous 64x9 ROM (input addr[5:0], output word[8:0], 1-cycle latency).

Verification
REQ-041 The bench SHALL use BEAT_CYCLES=10, GAP_CYCLES=2, SONG_LEN=4.
REQ-042 Test ROM SHALL be {A4 dur0, rest dur1, C4 dur0, B5 dur2}.
REQ-043 Scenario 1: start pulse at cycle 0 -> LOAD at cycle 1; NOTE at cycle 2 with note_div=113635 and mute=0 for 8 cycles; then mute=1 for 2 cycles; next LOAD at cycle 11.
REQ-044 Scenario 2: full song with loop_en=0 -> entry periods of 10, 20, 10 and 30 cycles; done_pulse exactly once; state DONE; playing=0.
REQ-045 Scenario 3: loop_en=1 -> song_idx goes 3->0 with done_pulse=1 for one cycle; A4 replays with no extra cycle inserted.
REQ-046 Scenario 4: pause held for 5 cycles mid-NOTE -> mute=1 during the pause; NOTE end delayed by exactly 5 cycles.
REQ-047 Scenario 5: stop and start asserted in the same cycle during NOTE -> IDLE next cycle, song_idx=0, mute=1.
REQ-048 Scenario 6: rst asserted during GAP of entry 2 -> all outputs at reset values next cycle and no done_pulse; a later start plays from entry 0.
